// File: rtl/ysyx_pkg.sv
// ============================================================================
// Module  : ysyx_pkg
// Brief   : Shared constants and types for the RV32E register file slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_pkg;

  localparam int REG_NUM = 16;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 2;

  typedef logic [CNT_W-1:0] ysyx_cnt_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_rf_pend_cnt.sv
// ============================================================================
// Module  : ysyx_rf_pend_cnt
// Brief   : Saturating up/down count of in-flight writers for one register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_rf_pend_cnt
  import ysyx_pkg::*;
#(
  parameter int CNT_W = ysyx_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic busy,
  output logic full
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // A simultaneous inc and dec cancel; both ends saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && !dec && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);
  assign full = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/ysyx_rf_scoreboard.sv
// ============================================================================
// Module  : ysyx_rf_scoreboard
// Brief   : RV32E register file with writeback bypass and pending-write table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_rf_scoreboard
  import ysyx_pkg::*;
#(
  parameter int BIT_W   = 32,
  parameter int REG_NUM = ysyx_pkg::REG_NUM,
  parameter int ADDR_W  = ysyx_pkg::ADDR_W,
  parameter int CNT_W   = ysyx_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  rs1,
  input  logic [ADDR_W-1:0]  rs2,
  output logic [BIT_W-1:0]   rdata1,
  output logic [BIT_W-1:0]   rdata2,
  input  logic               issue_valid,
  input  logic               issue_wen,
  input  logic [ADDR_W-1:0]  issue_rd,
  output logic               issue_full,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_rd,
  input  logic [BIT_W-1:0]   wb_data,
  input  logic               flush,
  output logic [REG_NUM-1:0] rf_table
);

  logic [BIT_W-1:0]   r_regs [REG_NUM];
  logic [REG_NUM-1:0] w_busy;
  logic [REG_NUM-1:0] w_full;
  logic               w_issue;

  // The committing instruction is older than anything squashed, so flush
  // does not block the register write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_valid && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  assign rdata1 = (wb_valid && (wb_rd == rs1) && (rs1 != '0)) ? wb_data : r_regs[rs1];
  assign rdata2 = (wb_valid && (wb_rd == rs2) && (rs2 != '0)) ? wb_data : r_regs[rs2];

  assign w_issue = issue_valid && issue_wen && !flush;

  assign w_busy[0] = 1'b0;
  assign w_full[0] = 1'b0;

  for (genvar g = 1; g < REG_NUM; g++) begin : g_cnt
    ysyx_rf_pend_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (w_issue && (issue_rd == ADDR_W'(g))),
      .dec  (wb_valid && (wb_rd == ADDR_W'(g))),
      .clr  (flush),
      .busy (w_busy[g]),
      .full (w_full[g])
    );
  end

  assign issue_full = issue_wen && (issue_rd != '0) && w_full[issue_rd];
  assign rf_table   = w_busy;

  // Decode must stall on issue_full; issuing anyway is a protocol violation.
  a_no_issue_when_full : assert property (
    @(posedge clk) disable iff (rst) !(issue_valid && issue_full && !flush)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_rf_scoreboard.sv
// ============================================================================
// Module  : tb_ysyx_rf_scoreboard
// Brief   : Directed and random checks of ysyx_rf_scoreboard against a model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1, rs2;
  logic [31:0] rdata1, rdata2;
  logic        issue_valid, issue_wen;
  logic [3:0]  issue_rd;
  logic        issue_full;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [15:0] rf_table;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural values and number of outstanding writers.
  logic [31:0] m_reg [16];
  int          m_cnt [16];

  always #5 clk = ~clk;

  ysyx_rf_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .rs1         (rs1),
    .rs2         (rs2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_rd    (issue_rd),
    .issue_full  (issue_full),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .rf_table    (rf_table)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] rs);
    if (rs == 0) return 32'h0;
    if (wb_valid && wb_rd == rs) return wb_data;
    return m_reg[rs];
  endfunction

  function automatic logic [15:0] exp_tbl();
    logic [15:0] t = '0;
    for (int i = 1; i < 16; i++) t[i] = (m_cnt[i] != 0);
    return t;
  endfunction

  function automatic logic exp_full();
    return issue_wen && issue_rd != 0 && m_cnt[issue_rd] == 3;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i] = 32'h0;
        m_cnt[i] = 0;
      end
      return;
    end
    if (wb_valid && wb_rd != 0) m_reg[wb_rd] = wb_data;
    for (int r = 1; r < 16; r++) begin
      bit inc = issue_valid && issue_wen && issue_rd == r && !flush;
      bit dec = wb_valid && wb_rd == r;
      if (flush) m_cnt[r] = 0;
      else if (inc && !dec) m_cnt[r] = (m_cnt[r] < 3) ? m_cnt[r] + 1 : 3;
      else if (dec && !inc) m_cnt[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    end
  endtask

  // Compare all outputs against the model before the edge, then advance.
  task automatic cyc();
    #1;
    chk("rdata1", rdata1, exp_rd(rs1));
    chk("rdata2", rdata2, exp_rd(rs2));
    chk("rf_table", {16'h0, rf_table}, {16'h0, exp_tbl()});
    chk("issue_full", {31'h0, issue_full}, {31'h0, exp_full()});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0; rst = 0;
  endtask

  task automatic issue(input logic [3:0] rd);
    idle();
    issue_valid = 1; issue_wen = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [3:0] rd, input logic [31:0] d);
    idle();
    wb_valid = 1; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    rs1 = 0; rs2 = 0;
    idle();
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = 32'h0;
      m_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Reset state
    rs1 = 5; rs2 = 0;
    #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_table", {16'h0, rf_table}, 32'h0);
    chk("rst_full", {31'h0, issue_full}, 32'h0);
    cyc();

    // Issue then commit with bypass
    issue(3); cyc();
    idle(); #1; chk("iss3_table", {16'h0, rf_table}, 32'h0008);
    cyc(); cyc();
    rs1 = 3; wb(3, 32'hDEADBEEF); #1;
    chk("bypass3", rdata1, 32'hDEADBEEF);
    cyc();
    idle(); #1;
    chk("wb3_table", {16'h0, rf_table}, 32'h0);
    chk("reg3", rdata1, 32'hDEADBEEF);
    cyc();

    // Three writers to x7
    repeat (3) begin issue(7); cyc(); end
    idle(); issue_wen = 1; issue_rd = 7; #1;
    chk("full7", {31'h0, issue_full}, 32'h1);
    wb(7, 32'h1); cyc();
    wb(7, 32'h2); cyc();
    idle(); #1; chk("bit7_held", {31'h0, rf_table[7]}, 32'h1);
    wb(7, 32'h3); cyc();
    idle(); #1; chk("bit7_clr", {31'h0, rf_table[7]}, 32'h0);
    cyc();

    // Same-cycle issue and writeback
    issue(2); cyc();
    issue(2); wb_valid = 1; wb_rd = 2; wb_data = 32'h55; cyc();
    idle(); rs1 = 2; #1;
    chk("bit2_held", {31'h0, rf_table[2]}, 32'h1);
    chk("reg2", rdata1, 32'h55);
    wb(2, 32'h55); cyc();
    idle(); #1; chk("bit2_clr", {31'h0, rf_table[2]}, 32'h0);

    // x0 handling
    rs1 = 0; issue(0); wb_valid = 1; wb_rd = 0; wb_data = 32'h1234; #1;
    chk("x0_bypass", rdata1, 32'h0);
    cyc();
    idle(); #1;
    chk("x0_table", {31'h0, rf_table[0]}, 32'h0);
    chk("x0_read", rdata1, 32'h0);
    cyc();

    // Flush with issue and writeback
    issue(4); cyc();
    issue(9); cyc();
    idle(); #1; chk("pend_4_9", {16'h0, rf_table}, 32'h0210);
    issue(11); wb_valid = 1; wb_rd = 4; wb_data = 32'h99; flush = 1; cyc();
    idle(); rs1 = 4; #1;
    chk("flush_table", {16'h0, rf_table}, 32'h0);
    chk("flush_reg4", rdata1, 32'h99);
    cyc();

    // Randomized traffic, with one mid-run reset
    for (int n = 0; n < 400; n++) begin
      idle();
      rs1 = 4'($urandom_range(0, 15));
      rs2 = 4'($urandom_range(0, 15));
      issue_rd    = 4'($urandom_range(0, 15));
      issue_wen   = ($urandom % 4) != 0;
      issue_valid = ($urandom % 2) == 0;
      if (issue_wen && issue_rd != 0 && m_cnt[issue_rd] == 3) issue_valid = 0;
      wb_valid = ($urandom % 2) == 0;
      wb_rd    = 4'($urandom_range(0, 15));
      wb_data  = $urandom;
      flush    = ($urandom % 40) == 0;
      rst      = (n == 200);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_rf_scoreboard.md
# ysyx_rf_scoreboard

Register file plus per-register pending-write scoreboard for the RV32E pipeline. Supplies the decode stage with combinational operand reads (`rs1`/`rs2` to `rdata1`/`rdata2`) and the `rf_table` busy vector it uses for hazard detection. Records every issued register write and retires it on writeback, so a busy bit clears only when the last in-flight writer of that register has committed. Sits between decode/issue and the writeback/commit stage. It is the writer side of the `rf_table` and operand interface.

## Interface
Parameters:
- `BIT_W`, 32, data width.
- `REG_NUM`, 16, architectural registers (RV32E).
- `ADDR_W`, 4, register index width.
- `CNT_W`, 2, pending-writer counter width; maximum in-flight writers per register is 2^CNT_W-1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rs1`, `rs2`  in  ADDR_W  read indices from decode.
- `rdata1`, `rdata2`  out  BIT_W  operand values, combinational.
- `issue_valid`  in  1  an instruction leaves decode this cycle (decode valid and execute ready).
- `issue_wen`  in  1  the issued instruction writes `issue_rd`.
- `issue_rd`  in  ADDR_W  destination of the issued instruction.
- `issue_full`  out  1  combinational; the counter of `issue_rd` is at maximum, so decode must stall.
- `wb_valid`  in  1  writeback commits this cycle.
- `wb_rd`  in  ADDR_W  writeback destination.
- `wb_data`  in  BIT_W  writeback value.
- `flush`  in  1  pipeline squash on misprediction.
- `rf_table`  out  REG_NUM  bit i is 1 when the counter of register i is nonzero; registered.

## Operation
- Register x0: reads 0, ignores writes, counter is held at 0, and `rf_table[0]` is always 0.
- Read path:
  - `rdataN = (wb_valid & wb_rd==rsN & rsN!=0) ? wb_data : regs[rsN]`.
  - The writeback bypass lets decode see a value in the cycle it commits.
- Write: on `wb_valid & wb_rd!=0`, `regs[wb_rd] <= wb_data` at the clock edge. The write happens even when `flush` is asserted, because the committing instruction is older than the squashed ones.
- Counter update per register r≠0:
  - `inc = issue_valid & issue_wen & issue_rd==r & !flush`.
  - `dec = wb_valid & wb_rd==r`.
  - Next value:
    - `flush`: 0.
    - `inc & dec`: unchanged.
    - `inc`: +1, saturating at max, never wraps.
    - `dec`: -1, saturating at 0, never underflows.
- `issue_full = issue_wen & issue_rd!=0 & cnt[issue_rd]==max`. Issuing while `issue_full` is a protocol violation: the counter stays at max and a simulation assertion fires.
- `rf_table[i] = (cnt[i] != 0)`, driven from counter state only.

## Timing
- Reset values:
  - All `regs` are 0 and all counters are 0.
  - `rf_table` is 0.
  - `rdata1`/`rdata2` read 0 with no writeback in flight; `issue_full` is 0.
- Issue at edge N sets `rf_table[rd]` visible from cycle N+1.
- Writeback of the last pending writer at edge N clears `rf_table[rd]` from cycle N+1. In cycle N itself, the bypass already provides the value.
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- Simultaneous issue and writeback to the same rd: the bit stays set and the counter is unchanged.
- `flush` together with issue: the issue is dropped and all counters go to 0.
- `rst` mid-operation clears everything at the next edge and overrides `flush`, issue and writeback.

## Structure
- Shared package `ysyx_pkg`: `REG_NUM`, `ADDR_W`, `CNT_W` constants and the `ysyx_cnt_t` counter typedef.
- One sub-module, `ysyx_rf_pend_cnt`: a single saturating up/down counter with `inc`, `dec`, `clr` inputs and `busy`, `full` outputs. It is instantiated REG_NUM-1 times via generate; x0 is tied off.

## Test plan
- Reset: assert `rst` for 2 cycles, then read `rs1`=5 and `rs2`=0. Required: `rdata1`=0, `rdata2`=0, `rf_table`=16'h0000, `issue_full`=0.
- Issue then commit: issue rd=3 at cycle 1. Required: `rf_table`=16'h0008 from cycle 2. At cycle 4, drive wb rd=3 with data 0xDEADBEEF. Required: `rdata1`(rs1=3)=0xDEADBEEF in cycle 4 via bypass, and `rf_table`=0 from cycle 5.
- Multiple writers: issue rd=7 three times.
  - After the third issue: `issue_full`=1 with `issue_rd`=7.
  - Two writebacks to rd=7: bit 7 remains 1.
  - Third writeback: bit 7 clears the next cycle.
- Same-cycle issue and writeback: with rd=2 pending (count 1), issue rd=2 and writeback rd=2 with data 0x55 in the same cycle. Required: `rf_table[2]` stays 1, `regs[2]`=0x55, and one further writeback clears the bit.
- x0 handling: issue rd=0 and writeback rd=0 with data 0x1234. Required: `rf_table[0]`=0 and `rdata1`(rs1=0)=0 in all cycles.
- Flush: with rd=4 and rd=9 pending, assert `flush` together with issue rd=11 and wb rd=4 data 0x99. Required: `rf_table`=0 the next cycle, `regs[4]`=0x99, and rd=11 is not marked busy.
